jk_count_sequencer: RTL and testbench
=====================================

Name: jk_count_sequencer

Overview:
- Controller that sequences a bank of WIDTH JK flip-flops through a load-then-count run.
- Accepts a start request and computes each bit's J/K drive: hold, load, toggle-up or toggle-down.
- Stops when the register equals a programmed stop value, then pulses done.
- Reuses the team's JK storage cell as its datapath; serves as the sequencing layer above the seqlogic primitives.

Parameters:
- WIDTH, 4, number of JK flip-flops in the bank and width of all value ports.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, run request; sampled only in IDLE.
- dir, input, 1, count direction: 1 = up, 0 = down; captured on start.
- load_val, input, WIDTH, initial register value; captured on start.
- stop_val, input, WIDTH, terminal value; captured on start.
- abort, input, 1, cancel an active run.
- busy, output, 1, high in LOAD and RUN.
- done, output, 1, one-cycle completion pulse.
- q, output, WIDTH, JK bank outputs.
- j_bus, output, WIDTH, J drive to the bank, exported for observability.
- k_bus, output, WIDTH, K drive to the bank, exported for observability.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, no clock edge needed):
  - state = IDLE; q = 0; busy = 0; done = 0; j_bus = k_bus = 0.
  - dir_r, load_r and stop_r are cleared.
  - Reset asserted mid-run cancels the run; no done pulse is produced.
- FSM is Moore with 4 states. busy and done decode from registered state. j_bus/k_bus are combinational from state, q and the captured registers.
- IDLE:
  - J = K = 0, so q holds.
  - start = 1 captures dir/load_val/stop_val into dir_r/load_r/stop_r and moves to LOAD.
- LOAD (exactly 1 cycle):
  - J = load_r, K = ~load_r, so q = load_r after the edge.
  - Next state RUN; abort = 1 moves to IDLE instead.
- RUN:
  - If q == stop_r: J = K = 0 and next state DONE.
  - Otherwise J = K = t, where t is the toggle vector.
    - Up: t[0] = 1; t[i] = &q[i-1:0].
    - Down: t[0] = 1; t[i] = &~q[i-1:0].
  - Counting wraps modulo 2^WIDTH (up: 15 -> 0; down: 0 -> 15 at WIDTH = 4).
- DONE (1 cycle):
  - done = 1, busy = 0, J = K = 0; next state IDLE.
  - start in this cycle is ignored.
- abort:
  - In LOAD or RUN: J = K = 0 that cycle, so q holds; next state IDLE; done is not asserted.
  - Ignored in IDLE and DONE.
  - Reset takes precedence over abort; abort takes precedence over the stop compare.
- start:
  - Ignored whenever state != IDLE; captured values do not change mid-run.
- Latency (start sampled at edge n, k = steps from load to stop):
  - q = load_val after edge n+1.
  - q == stop_val after edge n+1+k.
  - DONE entered at edge n+2+k, so done is high for exactly one cycle after that edge.
  - load_val == stop_val gives k = 0.
- Stop-value reachability:
  - Every stop_val is reachable within 2^WIDTH - 1 steps in either direction.
  - There is no timeout.

Decomposition:
- Shared package/header: state encoding localparams IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, DONE = 2'b11; DIR_UP = 1'b1, DIR_DN = 1'b0.
- Sub-module jk_cell: single JK flip-flop with asynchronous active-low reset to 0.
  - Ports: clk, rst_n, j, k, q, qbar.
  - Truth table: 00 hold, 01 reset, 10 set, 11 toggle.
  - Instantiated WIDTH times via generate.
- Sequencer logic (FSM, capture registers, toggle-vector generation, compare) lives in jk_count_sequencer.

Test Plan:
- Up run, WIDTH = 4: load_val = 3, stop_val = 7, dir = 1, start at edge 0.
  - Required: q = 3, 4, 5, 6, 7 after edges 1–5; done high only after edge 6; busy high after edges 1–5.
- Down wrap: load_val = 1, stop_val = 14, dir = 0.
  - Required: q = 1, 0, 15, 14; j_bus = k_bus = 4'b1111 on the 0 -> 15 step; single done pulse.
- Equal values: load_val = stop_val = 5.
  - Required: q = 5 after edge 1; done after edge 2; q never changes afterwards.
- Abort: load_val = 0, stop_val = 15, up, abort = 1 for one cycle while q = 4.
  - Required: q stays 4, state returns to IDLE, busy = 0, done never asserts.
- Start while busy, then reset mid-run:
  - Second start (different load_val) during RUN is ignored; q keeps counting from the original values.
  - rst_n low asynchronously between edges drives q = 0 and busy = 0 immediately; no done pulse.
  - A new start after rst_n release runs normally.

Source files
------------

// File: rtl/jk_count_sequencer_pkg.sv
// Shared definitions for the JK load-then-count sequencer: state encoding
// and count-direction codes.
package jk_count_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/jk_count_sequencer_jk_cell.sv
// Single JK storage cell: 00 hold, 01 reset, 10 set, 11 toggle.
// Asynchronous active-low reset clears the cell to 0.
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= 1'b0;
    end else begin
      case ({j, k})
        2'b00: q_reg <= q_reg;
        2'b01: q_reg <= 1'b0;
        2'b10: q_reg <= 1'b1;
        2'b11: q_reg <= ~q_reg;
      endcase
    end
  end

  assign q    = q_reg;
  assign qbar = ~q_reg;

endmodule

// File: rtl/jk_count_sequencer.sv
// Sequences a bank of JK cells through load-then-count runs, stopping when the
// bank matches a captured stop value and pulsing done for one cycle.
module jk_count_sequencer
  import jk_count_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] stop_val,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_bus,
  output logic [WIDTH-1:0] k_bus
);

  state_t           state_reg;
  logic             dir_reg;
  logic [WIDTH-1:0] load_reg;
  logic [WIDTH-1:0] stop_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [WIDTH-1:0] q_bus;
  logic [WIDTH-1:0] qbar_bus;
  logic [WIDTH-1:0] tog_up;
  logic [WIDTH-1:0] tog_dn;
  logic [WIDTH-1:0] tog;
  logic             at_stop;

  // A bit toggles when every lower bit is 1 (up) or every lower bit is 0 (down).
  assign tog_up[0] = 1'b1;
  assign tog_dn[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_tog
      assign tog_up[gi] = &q_bus[gi-1:0];
      assign tog_dn[gi] = &qbar_bus[gi-1:0];
    end
  endgenerate

  always_comb begin
    tog = tog_up;
    case (dir_reg)
      DIR_UP: tog = tog_up;
      DIR_DN: tog = tog_dn;
    endcase
  end

  // Equality built from both cell rails: a bit mismatches if q is 1 where stop
  // is 0, or qbar is 1 where stop is 1.
  assign at_stop = ~|((q_bus & ~stop_reg) | (qbar_bus & stop_reg));

  always_comb begin
    j_bus = '0;
    k_bus = '0;
    case (state_reg)
      LOAD: begin
        if (!abort) begin
          j_bus = load_reg;
          k_bus = ~load_reg;
        end
      end
      RUN: begin
        if (!abort && !at_stop) begin
          j_bus = tog;
          k_bus = tog;
        end
      end
      default: begin
        j_bus = '0;
        k_bus = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      dir_reg   <= DIR_DN;
      load_reg  <= '0;
      stop_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            dir_reg   <= dir;
            load_reg  <= load_val;
            stop_reg  <= stop_val;
            state_reg <= LOAD;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          // Abort wins over the stop compare, so an aborted run never reports done.
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (at_stop) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
      jk_cell u_cell (
        .clk  (clk),
        .rst_n(rst_n),
        .j    (j_bus[gi]),
        .k    (k_bus[gi]),
        .q    (q_bus[gi]),
        .qbar (qbar_bus[gi])
      );
    end
  endgenerate

  assign q    = q_bus;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Scoreboard bench: stimulus pushes the expected per-cycle view of the bank,
// a negedge monitor pops and compares it against the DUT.
module tb_jk_count_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] stop_val = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] j_bus;
  logic [W-1:0] k_bus;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic [W-1:0] j;
    logic [W-1:0] k;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_q = '0;

  always #5 clk = ~clk;

  jk_count_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dir     (dir),
    .load_val(load_val),
    .stop_val(stop_val),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .q       (q),
    .j_bus   (j_bus),
    .k_bus   (k_bus)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void push_exp(input logic [W-1:0] eq, input logic eb, input logic ed,
                                   input logic [W-1:0] ej, input logic [W-1:0] ek);
    exp_t e;
    e.q = eq; e.busy = eb; e.done = ed; e.j = ej; e.k = ek;
    exp_q.push_back(e);
  endfunction

  // Value n counting steps away from v, modulo 2^W.
  function automatic logic [W-1:0] advance(input logic [W-1:0] v, input bit up, input int n);
    int t;
    t = up ? int'(v) + n : int'(v) - n;
    return t[W-1:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("q", q, e.q);
      check("busy", W'(busy), W'(e.busy));
      check("done", W'(done), W'(e.done));
      check("j_bus", j_bus, e.j);
      check("k_bus", k_bus, e.k);
    end
  end

  task automatic scramble_inputs();
    dir      = 1'($urandom);
    load_val = W'($urandom);
    stop_val = W'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      abort = 1'($urandom);
      scramble_inputs();
      push_exp(model_q, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
    end
    abort = 1'b0;
  endtask

  // One run; abort_at/restart_at/rst_at index cycles after the start edge
  // (0 = load cycle), -1 disables.
  task automatic run_job(input bit d, input logic [W-1:0] lv, input logic [W-1:0] sv,
                         input int abort_at, input int restart_at, input int rst_at);
    int           steps;
    logic [W-1:0] v;
    logic [W-1:0] nx;
    steps = (d ? (int'(sv) - int'(lv)) : (int'(lv) - int'(sv))) & ((1 << W) - 1);
    $display("run dir=%0d load=%0d stop=%0d steps=%0d abort_at=%0d restart_at=%0d rst_at=%0d",
             d, lv, sv, steps, abort_at, restart_at, rst_at);
    start = 1'b1; dir = d; load_val = lv; stop_val = sv; abort = 1'b0;
    push_exp(model_q, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    for (int i = 0; i <= steps + 1; i++) begin
      start = (i == restart_at);
      abort = (i == abort_at);
      scramble_inputs();
      if (i == rst_at) begin
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_q", q, '0);
        check("rst_async_busy", W'(busy), '0);
        check("rst_async_done", W'(done), '0);
        check("rst_async_j", j_bus, '0);
        @(posedge clk); #1;
        check("rst_hold_q", q, '0);
        check("rst_hold_done", W'(done), '0);
        @(negedge clk);
        rst_n = 1'b1; abort = 1'b0;
        @(posedge clk); #1;
        model_q = '0;
        return;
      end
      v = (i == 0) ? model_q : advance(lv, d, i - 1);
      if (abort) begin
        push_exp(v, 1'b1, 1'b0, '0, '0);
      end else if (i == 0) begin
        push_exp(v, 1'b1, 1'b0, lv, ~lv);
      end else if (i <= steps) begin
        nx = advance(lv, d, i);
        push_exp(v, 1'b1, 1'b0, v ^ nx, v ^ nx);
      end else begin
        push_exp(v, 1'b1, 1'b0, '0, '0);
      end
      @(posedge clk); #1;
      if (i == abort_at) begin
        abort = 1'b0; start = 1'b0; model_q = v;
        return;
      end
    end
    // Completion cycle: start and abort here must have no effect.
    start = 1'($urandom);
    abort = 1'($urandom);
    scramble_inputs();
    push_exp(sv, 1'b0, 1'b1, '0, '0);
    model_q = sv;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_q", q, '0);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_j", j_bus, '0);
    check("reset_k", k_bus, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(2);

    run_job(1'b1, 4'd3, 4'd7, -1, -1, -1);
    idle_cycles(1);
    run_job(1'b0, 4'd1, 4'd14, -1, -1, -1);
    run_job(1'b1, 4'd5, 4'd5, -1, -1, -1);
    idle_cycles(3);
    run_job(1'b1, 4'd0, 4'd15, 5, -1, -1);
    idle_cycles(2);
    run_job(1'b1, 4'd2, 4'd9, -1, 3, -1);
    run_job(1'b0, 4'd6, 4'd1, -1, 2, 4);
    run_job(1'b1, 4'd12, 4'd2, -1, -1, -1);
    run_job(1'b1, 4'd9, 4'd4, 0, -1, -1);
    run_job(1'b0, 4'd4, 4'd4, 1, -1, -1);

    for (int n = 0; n < 25; n++) begin
      int ab;
      int rs;
      int rt;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : -1;
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 17)) : -1;
      rt = int'($urandom_range(0, 17));
      run_job(1'($urandom), W'($urandom), W'($urandom), ab, rt, rs);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(1);
    @(posedge clk); #1;
    check("scoreboard_drained", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
